fp_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider producing quotient = dividend / divisor.
- It is the inverse-operation companion to the team's pipelined FP multiplier. Speech-feature normalisation and energy-ratio stages use it where the datapath needs division rather than scaling.
- It takes a start/done handshake, performs restoring mantissa division at one bit per cycle, and rounds half-up.
- Latency is fixed, so schedulers can plan around it.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_mant_div.sv | 51 +++++
 rtl/fp_divider.sv | 145 ++++++++++++++
 tb/tb_fp_divider.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants and the divider FSM state type.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_EXP_MAX = 255;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    DIV   = 2'd2,
    ROUND = 2'd3
  } fp_state_t;

endpackage

// File: rtl/fp_mant_div.sv
// 25-bit restoring mantissa divider, one quotient bit per step, MSB first.
// After load, 25 steps yield floor(dividend * 2^24 / divisor).
module fp_mant_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [24:0] dividend,
  input  logic [23:0] divisor,
  output logic [24:0] quot,
  output logic        last
);

  logic [25:0] rem_q, rem_d;
  logic [23:0] div_q;
  logic [24:0] quot_q, quot_d;
  logic [4:0]  cnt_q;
  logic        ge;
  logic [25:0] sub;

  // One restoring step: subtract when possible, then shift the remainder up.
  always_comb begin
    ge     = rem_q >= {2'b00, div_q};
    sub    = rem_q - {2'b00, div_q};
    rem_d  = (ge ? sub : rem_q) << 1;
    quot_d = (quot_q << 1) | {24'd0, ge};
  end

  // Remainder, divisor, quotient and step counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= {1'b0, dividend};
      div_q  <= divisor;
      quot_q <= '0;
      cnt_q  <= 5'd24;
    end else if (step) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
    end
  end

  assign quot = quot_q;
  assign last = (cnt_q == 5'd0);

endmodule

// File: rtl/fp_divider.sv
// Iterative binary32 divider: start/done handshake, fixed 27-cycle latency,
// restoring mantissa division and round-half-up.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        overflow
);

  fp_state_t state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic              sign_q, dbz_case_q, zero_case_q;
  logic signed [9:0] exp_q;

  // Unpack signals
  logic [FP_EXP_W-1:0] e1, e2;
  logic [23:0]         m1, m2;
  logic                m_lt;
  logic [24:0]         dividend_al;
  logic signed [9:0]   exp_prep;

  // Mantissa divider signals
  logic [24:0] q;
  logic        div_last;

  // Round/pack signals
  logic [24:0]         man_sum;
  logic                man_carry;
  logic [FP_MAN_W-1:0] man_rnd;
  logic signed [9:0]   exp_rnd;
  logic [31:0]         result;
  logic                res_dbz, res_ovf;

  // Unpack latched operands and align the dividend so the quotient MSB is set.
  always_comb begin
    e1          = a_q[30:23];
    e2          = b_q[30:23];
    m1          = {1'b1, a_q[22:0]};
    m2          = {1'b1, b_q[22:0]};
    m_lt        = m1 < m2;
    dividend_al = m_lt ? {m1, 1'b0} : {1'b0, m1};
    exp_prep    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + $signed(10'(FP_BIAS))
                  - (m_lt ? 10'sd1 : 10'sd0);
  end

  fp_mant_div u_mant_div (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == PREP),
    .step     (state_q == DIV),
    .dividend (dividend_al),
    .divisor  (m2),
    .quot     (q),
    .last     (div_last)
  );

  // Round half-up on the guard bit and pack with special-case priority.
  always_comb begin
    man_sum   = {1'b0, q[24:1]} + {24'd0, q[0]};
    man_carry = man_sum[24];
    // On carry the low bits are already zero, which is the wanted mantissa.
    man_rnd   = man_sum[FP_MAN_W-1:0];
    exp_rnd   = exp_q + $signed({9'd0, man_carry});
    res_dbz   = 1'b0;
    res_ovf   = 1'b0;
    if (dbz_case_q) begin
      result  = FP_POS_INF | {sign_q, 31'd0};
      res_dbz = 1'b1;
    end else if (zero_case_q) begin
      result  = {sign_q, 31'd0};
    end else if (exp_rnd >= FP_EXP_MAX) begin
      result  = FP_POS_INF | {sign_q, 31'd0};
      res_ovf = 1'b1;
    end else if (exp_rnd <= 0) begin
      result  = {sign_q, 31'd0};
    end else begin
      result  = {sign_q, exp_rnd[7:0], man_rnd};
    end
  end

  // FSM next-state: IDLE -> PREP -> DIV (25 steps) -> ROUND -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = DIV;
      DIV:     if (div_last) state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, prep results, handshake and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      dbz_case_q  <= 1'b0;
      zero_case_q <= 1'b0;
      exp_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE && start) begin
        a_q  <= in1;
        b_q  <= in2;
        busy <= 1'b1;
      end
      if (state_q == PREP) begin
        sign_q      <= a_q[31] ^ b_q[31];
        dbz_case_q  <= (e2 == '0);
        zero_case_q <= (e1 == '0);
        exp_q       <= exp_prep;
      end
      if (state_q == ROUND) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        quotient    <= result;
        div_by_zero <= res_dbz;
        overflow    <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Directed bench for fp_divider: exact and rounded quotients, special cases,
// handshake corner cases and asynchronous reset.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        start = 1'b0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient;

  int n_checks = 0;
  int n_fail   = 0;

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in1   = 32'hDEAD_BEEF;
    in2   = 32'h1234_5678;
  endtask

  // Edges after acceptance until done; 0 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q_exp, input logic dz_exp, input logic ov_exp);
    int n;
    launch(a, b);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    check({tag, " latency"}, n, 32'd27);
    check({tag, " quotient"}, quotient, q_exp);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dz_exp});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, ov_exp});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    int first;
    int saw;

    // Power-on reset
    #1 rst = 1'b1;
    #2;
    check("reset quotient", quotient, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Exact and rounded quotients; each start after the first lands in the done cycle.
    run("6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    run("-7.5/2.5", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0, 1'b0);
    run("1/1", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    run("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
    run("2/3", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 1'b0);

    // Special cases and range limits
    run("div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0);
    run("zero_dividend", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    run("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b1);
    run("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0);

    // Start while busy is dropped
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (4) begin @(posedge clk); #1; end
    in1   = 32'h3F80_0000;
    in2   = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n_done = 0;
    first  = 0;
    for (int n = 6; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first == 0) first = n;
      end
    end
    check("busy_start first_done", first, 32'd27);
    check("busy_start done_count", n_done, 32'd1);
    check("busy_start quotient", quotient, 32'h4040_0000);

    // Asynchronous reset mid-operation, after a result with a flag set
    run("div0_pre_reset", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst quotient", quotient, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("midrst overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    check("midrst no_done", saw, 32'd0);
    run("after_reset 2/3", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
